// File: rtl/serial_bit_feeder.sv
// -----------------------------------------------------------------------------
// serial_bit_feeder
//
// Parallel-to-serial stage that sits directly upstream of the sequence
// detector. Words are accepted over a valid/ready handshake and shifted out
// one bit at a time on o_ser_out. Each bit is held for CLKS_PER_BIT clocks.
// Back-to-back words stream with no idle gap, because a new word can be
// accepted on the final clock of the current frame.
//
// Build option:
//   SERIAL_BIT_FEEDER_PARITY_EN  when defined, an even-parity bit (^word) is
//                                appended after the data bits. A frame is then
//                                DATA_W+1 bits long. When not defined, there is
//                                no parity state and no parity logic.
//
// Parameters:
//   DATA_W        word width in bits (>= 2)
//   CLKS_PER_BIT  clocks each bit is held on o_ser_out (>= 1)
//   MSB_FIRST     1: i_in_data[DATA_W-1] is sent first, 0: i_in_data[0] first
//   IDLE_LEVEL    o_ser_out level when no frame is active
//
// Ports:
//   i_clk         clock, all logic on posedge
//   i_rst         asynchronous active-high reset
//   i_in_data     word to serialise, sampled only on accept
//   i_in_valid    upstream has a word
//   o_in_ready    block can accept a word this cycle (forced low during reset)
//   o_ser_out     registered serial bit stream
//   o_ser_strobe  high on the first clock of each transmitted bit
//   o_busy        high while a frame is being shifted out
//   o_frame_done  one-cycle pulse on the final clock of a frame's last bit
//
// States:
//   ST_IDLE   | no frame active, o_ser_out at IDLE_LEVEL, ready for a word
//   ST_SHIFT  | data bits being shifted out
//   ST_PARITY | parity bit being sent (parity build only)
// -----------------------------------------------------------------------------
module serial_bit_feeder #(
    parameter int   DATA_W       = 8,
    parameter int   CLKS_PER_BIT = 1,
    parameter int   MSB_FIRST    = 1,
    parameter logic IDLE_LEVEL   = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_in_data,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    output logic              o_ser_out,
    output logic              o_ser_strobe,
    output logic              o_busy,
    output logic              o_frame_done
);

    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam int DIV_W = $clog2(CLKS_PER_BIT) + 1;

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);

`ifdef SERIAL_BIT_FEEDER_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1
    } state_t;
`endif

    state_t             r_state;
    logic [DATA_W-1:0]  r_shift;
    logic [BIT_W-1:0]   r_bit_cnt;
    logic [DIV_W-1:0]   r_div_cnt;
    logic               r_ser_out;
    logic               r_busy;
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
    logic               r_parity;
`endif

    logic               w_first_bit;
    logic               w_next_bit;
    logic [DATA_W-1:0]  w_shifted;
    logic               w_last_clk;
    logic               w_last_bit;
    logic               w_frame_end;
    logic               w_accept;

    // The current bit always sits at the sending end of r_shift; the next bit
    // is its neighbour, so advancing is a single shift toward that end.
    assign w_first_bit = (MSB_FIRST != 0) ? i_in_data[DATA_W-1] : i_in_data[0];
    assign w_next_bit  = (MSB_FIRST != 0) ? r_shift[DATA_W-2]   : r_shift[1];
    assign w_shifted   = (MSB_FIRST != 0) ? {r_shift[DATA_W-2:0], 1'b0}
                                          : {1'b0, r_shift[DATA_W-1:1]};

    assign w_last_clk = (r_div_cnt == DIV_LAST);
    assign w_last_bit = (r_bit_cnt == BIT_LAST);

`ifdef SERIAL_BIT_FEEDER_PARITY_EN
    assign w_frame_end = (r_state == ST_PARITY) && w_last_clk;
`else
    assign w_frame_end = (r_state == ST_SHIFT) && w_last_clk && w_last_bit;
`endif

    // Ready depends only on state and counters, never on i_in_valid, so there
    // is no combinational loop through an upstream that waits for ready.
    assign o_in_ready = !i_rst && ((r_state == ST_IDLE) || w_frame_end);
    assign w_accept   = i_in_valid && o_in_ready;

    // Strobe and frame_done are pure decodes of registered state, so they
    // carry no path from the inputs.
    assign o_ser_strobe = (r_state != ST_IDLE) && (r_div_cnt == '0);
    assign o_frame_done = w_frame_end;
    assign o_ser_out    = r_ser_out;
    assign o_busy       = r_busy;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_div_cnt <= '0;
            r_ser_out <= IDLE_LEVEL;
            r_busy    <= 1'b0;
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_shift   <= i_in_data;
                        r_bit_cnt <= '0;
                        r_div_cnt <= '0;
                        r_state   <= ST_SHIFT;
                        r_ser_out <= w_first_bit;
                        r_busy    <= 1'b1;
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
                        r_parity  <= ^i_in_data;
`endif
                    end
                end

                ST_SHIFT: begin
                    if (!w_last_clk) begin
                        r_div_cnt <= r_div_cnt + 1'b1;
                    end else begin
                        r_div_cnt <= '0;
                        if (!w_last_bit) begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            r_shift   <= w_shifted;
                            r_ser_out <= w_next_bit;
                        end else begin
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
                            // bit_cnt reaches DATA_W here, which is why it is
                            // sized to hold DATA_W rather than DATA_W-1.
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            r_state   <= ST_PARITY;
                            r_ser_out <= r_parity;
`else
                            if (w_accept) begin
                                r_shift   <= i_in_data;
                                r_bit_cnt <= '0;
                                r_ser_out <= w_first_bit;
                            end else begin
                                r_bit_cnt <= '0;
                                r_state   <= ST_IDLE;
                                r_ser_out <= IDLE_LEVEL;
                                r_busy    <= 1'b0;
                            end
`endif
                        end
                    end
                end

`ifdef SERIAL_BIT_FEEDER_PARITY_EN
                ST_PARITY: begin
                    if (!w_last_clk) begin
                        r_div_cnt <= r_div_cnt + 1'b1;
                    end else begin
                        r_div_cnt <= '0;
                        r_bit_cnt <= '0;
                        if (w_accept) begin
                            r_shift   <= i_in_data;
                            r_state   <= ST_SHIFT;
                            r_ser_out <= w_first_bit;
                            r_parity  <= ^i_in_data;
                        end else begin
                            r_state   <= ST_IDLE;
                            r_ser_out <= IDLE_LEVEL;
                            r_busy    <= 1'b0;
                        end
                    end
                end
`endif

                default: begin
                    r_state   <= ST_IDLE;
                    r_bit_cnt <= '0;
                    r_div_cnt <= '0;
                    r_ser_out <= IDLE_LEVEL;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
